// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run/stop/split controller:
// state encoding, BCD time layout and hold-timer width.
package stopwatch_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int TIME_W     = DIGIT_W * NUM_DIGITS;

  // Field offsets inside the {min10, min1, sec10, sec1, csec10, csec1} word
  localparam int CSEC1_OFS  = 0;
  localparam int CSEC10_OFS = 4;
  localparam int SEC1_OFS   = 8;
  localparam int SEC10_OFS  = 12;
  localparam int MIN1_OFS   = 16;
  localparam int MIN10_OFS  = 20;

  localparam int TIMER_W = 10;

  localparam logic [DIGIT_W-1:0] LAPCNT_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_SPLIT_ENC = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_RUN   = ST_RUN_ENC,
    S_SPLIT = ST_SPLIT_ENC,
    S_STOP  = ST_STOP_ENC
  } sw_state_e;

  // Single BCD digit increment that sticks at 9 instead of wrapping
  function automatic logic [DIGIT_W-1:0] bcd_sat_inc(input logic [DIGIT_W-1:0] v);
    return (v >= LAPCNT_MAX) ? LAPCNT_MAX : v + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/display outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic                EN10MS;
  logic                SS;
  logic                LAP;
  logic [TIME_W-1:0]   TIME;
  logic                CNTEN;
  logic                CLR;
  logic [TIME_W-1:0]   DISP;
  logic                RUNNING;
  logic                HOLDING;
  logic [DIGIT_W-1:0]  LAPCNT;

  modport master (
    output EN10MS, SS, LAP, TIME,
    input  CNTEN, CLR, DISP, RUNNING, HOLDING, LAPCNT
  );

  modport slave (
    input  EN10MS, SS, LAP, TIME,
    output CNTEN, CLR, DISP, RUNNING, HOLDING, LAPCNT
  );

endinterface

// File: rtl/stopwatch_ctrl_hold_timer.sv
// Loadable down-counter that measures the split display hold in 10 ms ticks.
module hold_timer
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // A load on the same cycle as a tick restarts the hold; the tick is not counted
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/split controller: gates the counter enable, issues the clear and
// freezes a lap time on the display for HOLD_TICKS ticks while counting continues.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int HOLD_TICKS = 300
) (
  input  logic             CLK,
  input  logic             RST,
  stopwatch_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_TICKS - 1);

  sw_state_e           state_q, state_d;
  logic [TIME_W-1:0]   lap_q, lap_d;
  logic [DIGIT_W-1:0]  lapcnt_q, lapcnt_d;
  logic                clr_q, clr_d;
  logic                running_q, running_d;
  logic                holding_q, holding_d;
  logic                tmr_load;
  logic                tmr_tick;
  logic                tmr_zero;

  hold_timer u_hold_timer (
    .clk      (CLK),
    .srst     (RST),
    .load     (tmr_load),
    .load_val (HOLD_LOAD),
    .tick     (tmr_tick),
    .zero     (tmr_zero)
  );

  // SS always beats LAP, and any button beats hold expiry
  always_comb begin
    state_d  = state_q;
    lap_d    = lap_q;
    lapcnt_d = lapcnt_q;
    clr_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.SS) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.SS) begin
          state_d = S_STOP;
        end else if (bus.LAP) begin
          state_d  = S_SPLIT;
          lap_d    = bus.TIME;
          lapcnt_d = bcd_sat_inc(lapcnt_q);
          tmr_load = 1'b1;
        end
      end
      S_SPLIT: begin
        if (bus.SS) begin
          state_d = S_STOP;
        end else if (bus.LAP) begin
          lap_d    = bus.TIME;
          lapcnt_d = bcd_sat_inc(lapcnt_q);
          tmr_load = 1'b1;
        end else if (bus.EN10MS) begin
          if (tmr_zero) state_d = S_RUN;
          else          tmr_tick = 1'b1;
        end
      end
      S_STOP: begin
        if (bus.SS) begin
          state_d = S_RUN;
        end else if (bus.LAP) begin
          state_d  = S_IDLE;
          clr_d    = 1'b1;
          lapcnt_d = '0;
          lap_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN) || (state_d == S_SPLIT);
    holding_d = (state_d == S_SPLIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      lap_q     <= '0;
      lapcnt_q  <= '0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_q     <= lap_d;
      lapcnt_q  <= lapcnt_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      holding_q <= holding_d;
    end
  end

  assign bus.CNTEN   = bus.EN10MS & running_q;
  assign bus.CLR     = clr_q;
  assign bus.RUNNING = running_q;
  assign bus.HOLDING = holding_q;
  assign bus.LAPCNT  = lapcnt_q;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
    assign bus.DISP[gi*DIGIT_W +: DIGIT_W] =
      holding_q ? lap_q[gi*DIGIT_W +: DIGIT_W] : bus.TIME[gi*DIGIT_W +: DIGIT_W];
  end

endmodule
